// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store.
// One access is in flight at a time; the granted port sees a one-cycle ack with its read data.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_ack,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  port_q, port_d;   // 1 = data port owns the current transaction
   logic                  last_q, last_d;   // 1 = data port was granted last
   logic                  we_q, we_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
   logic                  if_ack_q, if_ack_d;
   logic                  dm_ack_q, dm_ack_d;
   logic                  busy_q, busy_d;

   logic grant_any;
   logic grant_dm;

   // On a tie the port that was not served last wins.
   assign grant_any = if_req | dm_req;
   assign grant_dm  = dm_req & (~if_req | ~last_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         port_q      <= 1'b0;
         last_q      <= 1'b1;
         we_q        <= 1'b0;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         port_q      <= port_d;
         last_q      <= last_d;
         we_q        <= we_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_any) state_d = ISSUE;
         ISSUE:   state_d = we_q ? RESP : WAIT;
         WAIT:    if (cnt_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Computes the next value of every registered output and datapath register.
   always_comb begin
      port_d      = port_q;
      last_d      = last_q;
      we_d        = we_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      busy_d      = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               port_d      = grant_dm;
               last_d      = grant_dm;
               we_d        = grant_dm & dm_we;
               mem_addr_d  = grant_dm ? dm_addr : if_addr;
               mem_wdata_d = grant_dm ? dm_wdata : '0;
               mem_en_d    = 1'b1;
               mem_we_d    = grant_dm & dm_we;
            end
         end
         ISSUE: begin
            if (we_q) begin
               dm_ack_d = port_q;
               if_ack_d = ~port_q;
            end else begin
               cnt_d = CNT_W'(MEM_LATENCY - 1);
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               if (port_q) begin
                  dm_rdata_d = mem_rdata;
                  dm_ack_d   = 1'b1;
               end else begin
                  if_rdata_d = mem_rdata;
                  if_ack_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign if_rdata  = if_rdata_q;
   assign if_ack    = if_ack_q;
   assign dm_rdata  = dm_rdata_q;
   assign dm_ack    = dm_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at latencies 2, 1 and 7,
// each with a fixed-latency read-only memory model.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int N  = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          if_req   [N];
   logic [AW-1:0] if_addr  [N];
   logic [DW-1:0] if_rdata [N];
   logic          if_ack   [N];
   logic          dm_req   [N];
   logic          dm_we    [N];
   logic [AW-1:0] dm_addr  [N];
   logic [DW-1:0] dm_wdata [N];
   logic [DW-1:0] dm_rdata [N];
   logic          dm_ack   [N];
   logic          mem_en   [N];
   logic          mem_we   [N];
   logic [AW-1:0] mem_addr [N];
   logic [DW-1:0] mem_wdata[N];
   logic [DW-1:0] mem_rdata[N];
   logic          busy     [N];

   int checks = 0;
   int errors = 0;

   function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
      if (a == 16'h0010) return 32'hDEADBEEF;
      return {a, ~a};
   endfunction

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 7);
      logic [AW-1:0] pend_addr = '0;
      int            pend_cnt  = 0;

      mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .if_req   (if_req[gi]),
         .if_addr  (if_addr[gi]),
         .if_rdata (if_rdata[gi]),
         .if_ack   (if_ack[gi]),
         .dm_req   (dm_req[gi]),
         .dm_we    (dm_we[gi]),
         .dm_addr  (dm_addr[gi]),
         .dm_wdata (dm_wdata[gi]),
         .dm_rdata (dm_rdata[gi]),
         .dm_ack   (dm_ack[gi]),
         .mem_en   (mem_en[gi]),
         .mem_we   (mem_we[gi]),
         .mem_addr (mem_addr[gi]),
         .mem_wdata(mem_wdata[gi]),
         .mem_rdata(mem_rdata[gi]),
         .busy     (busy[gi])
      );

      // Read data is only valid in the single cycle LAT cycles after the mem_en cycle.
      always @(posedge clk) begin
         if (!rst_n) pend_cnt <= 0;
         else if (mem_en[gi] && !mem_we[gi]) begin
            pend_addr <= mem_addr[gi];
            pend_cnt  <= LAT;
         end else if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
      end
      assign mem_rdata[gi] = (pend_cnt == 1) ? memval(pend_addr) : 32'hBAD0BAD0;
   end

   typedef struct {
      logic          ireq;
      logic [AW-1:0] iaddr;
      logic          dreq;
      logic          dwe;
      logic [AW-1:0] daddr;
      logic [DW-1:0] dwd;
      logic          en;
      logic          we;
      logic [AW-1:0] ma;
      logic [DW-1:0] mwd;
      logic          iack;
      logic          dack;
      logic          bsy;
      logic [DW-1:0] ird;
      logic [DW-1:0] drd;
   } vec_t;

   vec_t vecs [0:16];

   function automatic vec_t mk(input logic ireq, input logic [AW-1:0] iaddr,
                               input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                               input logic [DW-1:0] dwd, input logic en, input logic we,
                               input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
                               input logic iack, input logic dack, input logic bsy,
                               input logic [DW-1:0] ird, input logic [DW-1:0] drd);
      vec_t v;
      v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.daddr = daddr;
      v.dwd = dwd; v.en = en; v.we = we; v.ma = ma; v.mwd = mwd;
      v.iack = iack; v.dack = dack; v.bsy = bsy; v.ird = ird; v.drd = drd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_zero(input int k, input string name);
      chk({name, "_mem_en"},    32'(mem_en[k]), 0);
      chk({name, "_mem_we"},    32'(mem_we[k]), 0);
      chk({name, "_mem_addr"},  32'(mem_addr[k]), 0);
      chk({name, "_mem_wdata"}, mem_wdata[k], 0);
      chk({name, "_if_ack"},    32'(if_ack[k]), 0);
      chk({name, "_dm_ack"},    32'(dm_ack[k]), 0);
      chk({name, "_busy"},      32'(busy[k]), 0);
      chk({name, "_if_rdata"},  if_rdata[k], 0);
      chk({name, "_dm_rdata"},  dm_rdata[k], 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Back-to-back fetch loads on instance k; checks grant and ack cycles and data.
   task automatic sweep(input int k, input int lat);
      int            start;
      int            cyc;
      int            ntx;
      logic [AW-1:0] a;
      a     = 16'h0100;
      ntx   = 0;
      cyc   = 0;
      start = 0;
      @(posedge clk);
      #1;
      if_req[k]  = 1'b1;
      if_addr[k] = a;
      while (ntx < 3 && cyc < 200) begin
         @(negedge clk);
         if (mem_en[k]) begin
            chk($sformatf("sweep_l%0d_en_cycle", lat), 32'(cyc), 32'(start + 1));
            chk($sformatf("sweep_l%0d_addr", lat), 32'(mem_addr[k]), 32'(a));
         end
         if (if_ack[k]) begin
            chk($sformatf("sweep_l%0d_ack_cycle", lat), 32'(cyc - start), 32'(2 + lat));
            chk($sformatf("sweep_l%0d_rdata", lat), if_rdata[k], memval(a));
            $display("txn latency=%0d fetch addr=%h data=%h ack_cycle=%0d",
                     lat, a, if_rdata[k], cyc - start);
            ntx++;
            a          = a + 16'h1;
            if_addr[k] = a;
            start      = cyc + 1;
            if (ntx == 3) if_req[k] = 1'b0;
         end
         cyc++;
      end
      chk($sformatf("sweep_l%0d_tx_count", lat), 32'(ntx), 3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int            nif;
      int            ndm;
      int            ngr;
      logic [AW-1:0] fa;
      logic [AW-1:0] da;
      bit            found;

      rst_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         if_req[k] = 1'b0; if_addr[k] = '0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
         dm_addr[k] = '0; dm_wdata[k] = '0;
      end

      vecs[0]  = mk(0,16'h0000, 0,0,16'h0000,32'h0, 0,0,16'h0000,32'h0, 0,0,0, 32'h0,32'h0);
      vecs[1]  = mk(1,16'h0010, 0,0,16'h0000,32'h0, 0,0,16'h0000,32'h0, 0,0,0, 32'h0,32'h0);
      vecs[2]  = mk(1,16'h0010, 0,0,16'h0000,32'h0, 1,0,16'h0010,32'h0, 0,0,1, 32'h0,32'h0);
      vecs[3]  = mk(1,16'h0010, 0,0,16'h0000,32'h0, 0,0,16'h0010,32'h0, 0,0,1, 32'h0,32'h0);
      vecs[4]  = mk(1,16'h0010, 0,0,16'h0000,32'h0, 0,0,16'h0010,32'h0, 0,0,1, 32'h0,32'h0);
      vecs[5]  = mk(1,16'h0010, 0,0,16'h0000,32'h0, 0,0,16'h0010,32'h0, 1,0,1, 32'hDEADBEEF,32'h0);
      vecs[6]  = mk(0,16'h0000, 0,0,16'h0000,32'h0, 0,0,16'h0010,32'h0, 0,0,0, 32'hDEADBEEF,32'h0);
      vecs[7]  = mk(0,16'h0000, 1,1,16'h0200,32'h12345678, 0,0,16'h0010,32'h0, 0,0,0, 32'hDEADBEEF,32'h0);
      vecs[8]  = mk(0,16'h0000, 1,1,16'h0200,32'h12345678, 1,1,16'h0200,32'h12345678, 0,0,1, 32'hDEADBEEF,32'h0);
      vecs[9]  = mk(0,16'h0000, 1,1,16'h0200,32'h12345678, 0,0,16'h0200,32'h0, 0,1,1, 32'hDEADBEEF,32'h0);
      vecs[10] = mk(0,16'h0000, 0,0,16'h0000,32'h0, 0,0,16'h0200,32'h0, 0,0,0, 32'hDEADBEEF,32'h0);
      vecs[11] = mk(0,16'h0000, 1,0,16'h0300,32'h0, 0,0,16'h0200,32'h0, 0,0,0, 32'hDEADBEEF,32'h0);
      vecs[12] = mk(0,16'h0000, 1,0,16'h0300,32'h0, 1,0,16'h0300,32'h0, 0,0,1, 32'hDEADBEEF,32'h0);
      vecs[13] = mk(0,16'h0000, 1,0,16'h0300,32'h0, 0,0,16'h0300,32'h0, 0,0,1, 32'hDEADBEEF,32'h0);
      vecs[14] = mk(0,16'h0000, 1,0,16'h0300,32'h0, 0,0,16'h0300,32'h0, 0,0,1, 32'hDEADBEEF,32'h0);
      vecs[15] = mk(0,16'h0000, 1,0,16'h0300,32'h0, 0,0,16'h0300,32'h0, 0,1,1, 32'hDEADBEEF,32'h0300FCFF);
      vecs[16] = mk(0,16'h0000, 0,0,16'h0000,32'h0, 0,0,16'h0300,32'h0, 0,0,0, 32'hDEADBEEF,32'h0300FCFF);

      // Reset held with random inputs on every instance.
      repeat (4) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if_req[k] = 1'($urandom); if_addr[k] = AW'($urandom);
            dm_req[k] = 1'($urandom); dm_we[k] = 1'($urandom);
            dm_addr[k] = AW'($urandom); dm_wdata[k] = $urandom;
         end
         @(negedge clk);
         for (int k = 0; k < N; k++) check_zero(k, "reset_hold");
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if_req[k] = 1'b0; if_addr[k] = '0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
         dm_addr[k] = '0; dm_wdata[k] = '0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_zero(0, "post_reset");
      end

      // Cycle-by-cycle vectors: fetch load, data store, data load.
      for (int i = 0; i <= 16; i++) begin
         @(posedge clk);
         #1;
         if_req[0]   = vecs[i].ireq;
         if_addr[0]  = vecs[i].iaddr;
         dm_req[0]   = vecs[i].dreq;
         dm_we[0]    = vecs[i].dwe;
         dm_addr[0]  = vecs[i].daddr;
         dm_wdata[0] = vecs[i].dwd;
         @(negedge clk);
         chk($sformatf("v%0d_mem_en", i),   32'(mem_en[0]),   32'(vecs[i].en));
         chk($sformatf("v%0d_mem_we", i),   32'(mem_we[0]),   32'(vecs[i].we));
         chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr[0]), 32'(vecs[i].ma));
         if (vecs[i].en && vecs[i].we)
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata[0], vecs[i].mwd);
         chk($sformatf("v%0d_if_ack", i),   32'(if_ack[0]),   32'(vecs[i].iack));
         chk($sformatf("v%0d_dm_ack", i),   32'(dm_ack[0]),   32'(vecs[i].dack));
         chk($sformatf("v%0d_busy", i),     32'(busy[0]),     32'(vecs[i].bsy));
         chk($sformatf("v%0d_if_rdata", i), if_rdata[0],      vecs[i].ird);
         chk($sformatf("v%0d_dm_rdata", i), dm_rdata[0],      vecs[i].drd);
      end

      // Contention from reset: both ports keep requesting for six transactions.
      do_reset();
      fa = 16'h1000;
      da = 16'h2000;
      nif = 0;
      ndm = 0;
      ngr = 0;
      @(posedge clk);
      #1;
      if_req[0] = 1'b1; if_addr[0] = fa;
      dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = da;
      for (int c = 0; c < 100 && (nif + ndm) < 6; c++) begin
         @(negedge clk);
         if (mem_en[0]) begin
            chk($sformatf("cont_grant%0d_port", ngr), 32'(mem_addr[0][13]), 32'(ngr % 2));
            ngr++;
         end
         if (if_ack[0] || dm_ack[0])
            chk("cont_ack_exclusive", 32'(if_ack[0] & dm_ack[0]), 0);
         if (if_ack[0]) begin
            chk("cont_if_rdata", if_rdata[0], memval(fa));
            $display("txn contention fetch addr=%h data=%h", fa, if_rdata[0]);
            nif++;
            fa = fa + 16'h1;
            if_addr[0] = fa;
         end
         if (dm_ack[0]) begin
            chk("cont_dm_rdata", dm_rdata[0], memval(da));
            $display("txn contention data addr=%h data=%h", da, dm_rdata[0]);
            ndm++;
            da = da + 16'h1;
            dm_addr[0] = da;
         end
         if ((nif + ndm) == 6) begin
            if_req[0] = 1'b0;
            dm_req[0] = 1'b0;
         end
      end
      chk("cont_if_acks", 32'(nif), 3);
      chk("cont_dm_acks", 32'(ndm), 3);
      chk("cont_grants", 32'(ngr), 6);

      // Reset asserted while a load waits for memory.
      @(posedge clk);
      #1;
      if_req[0] = 1'b1;
      if_addr[0] = 16'h0044;
      @(negedge clk);
      @(negedge clk);
      chk("rst_issue_en", 32'(mem_en[0]), 1);
      @(negedge clk);
      chk("rst_wait_busy", 32'(busy[0]), 1);
      rst_n = 1'b0;
      if_req[0] = 1'b0;
      #1;
      chk("rst_async_en", 32'(mem_en[0]), 0);
      chk("rst_async_if_ack", 32'(if_ack[0]), 0);
      chk("rst_async_dm_ack", 32'(dm_ack[0]), 0);
      chk("rst_async_busy", 32'(busy[0]), 0);
      chk("rst_async_if_rdata", if_rdata[0], 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("rst_no_ack_after_release", 32'(if_ack[0]), 0);
         chk("rst_idle_busy", 32'(busy[0]), 0);
      end
      @(posedge clk);
      #1;
      if_req[0] = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (if_ack[0]) begin
            found = 1'b1;
            chk("rst_reraise_ack_cycle", 32'(c), 4);
            chk("rst_reraise_rdata", if_rdata[0], memval(16'h0044));
            $display("txn reraise fetch addr=0044 data=%h ack_cycle=%0d", if_rdata[0], c);
            if_req[0] = 1'b0;
         end
      end
      chk("rst_reraise_ack_seen", 32'(found), 1);

      sweep(1, 1);
      sweep(2, 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
